mem_access_stage: RTL and testbench
===================================

// Module: mem_access_stage
// PURPOSE
//  Pipelined memory-access stage between execute and writeback. Drives the data bus with a
//  valid/addr_ok/data_ok handshake and supports byte/half/word/double loads and stores.
//  Loads are sign- or zero-extended; stores get lane strobes. Holds at most one transaction
//  in flight and stalls upstream while busy. Misaligned accesses are flagged, never issued.
// PARAMETERS
//  XLEN    64  data/address width; power of two, >=32; bus lanes = XLEN/8
//  OFF_W   $clog2(XLEN/8)  byte-offset bits within a bus beat (derived)
// PORTS
//  clk            in   1       clock
//  reset          in   1       synchronous, active-high reset
//  in_valid       in   1       execute-stage op valid
//  in_ready       out  1       stage can accept (0 = stall upstream)
//  in_mem_op      in   2       0 none, 1 load, 2 store, 3 reserved (treated as none)
//  in_size        in   2       log2 bytes: 0 B, 1 H, 2 W, 3 D (3 illegal if XLEN=32 -> misalign)
//  in_unsigned    in   1       load zero-extends when 1
//  in_addr        in   XLEN    effective address (ALU result)
//  in_wdata       in   XLEN    store data (rs2), right-aligned
//  in_result      in   XLEN    writeback value for non-memory ops
//  out_valid      out  1       result valid to writeback
//  out_ready      in   1       writeback accepts
//  out_result     out  XLEN    load data or passthrough result; addr on misalign
//  out_misalign   out  1       access address not size-aligned
//  dreq_valid     out  1       bus request valid
//  dreq_addr      out  XLEN    request address (unmodified in_addr)
//  dreq_size      out  2       = in_size
//  dreq_strobe    out  XLEN/8  byte-write enables; all 0 for loads
//  dreq_data      out  XLEN    store data shifted to lane
//  dresp_addr_ok  in   1       bus accepted request this cycle
//  dresp_data_ok  in   1       bus completed request this cycle
//  dresp_data     in   XLEN    full-beat read data, valid with data_ok
// BEHAVIOUR
//  FSM states: IDLE, REQ, WAIT, OUT. Reset -> IDLE; out_valid=0, dreq_valid=0, strobe=0,
//   out_misalign=0, out_result=0. in_ready=1 only in IDLE, or OUT when out_ready=1.
//  Accept (in_valid & in_ready): latch all in_* into request reg.
//   mem_op none/reserved -> OUT next cycle, out_result=in_result (1-cycle latency).
//   misaligned (addr[size-1:0]!=0, or size=3 with XLEN=32) -> OUT, out_misalign=1,
//    out_result=in_addr, no bus traffic.
//   aligned load/store -> REQ.
//  REQ: dreq_valid=1, all dreq_* stable until addr_ok. addr_ok&data_ok same cycle -> OUT;
//   addr_ok alone -> WAIT (dreq_valid drops next cycle). data_ok without addr_ok ignored.
//  WAIT: dreq_valid=0; on data_ok -> OUT, capture load result.
//  OUT: out_valid=1, outputs stable until out_ready. out_ready & in_valid -> accept next op
//   same cycle (back-to-back); out_ready & !in_valid -> IDLE.
//  Store lanes: off=addr[OFF_W-1:0]; strobe=((1<<(1<<size))-1)<<off; dreq_data=
//   (in_wdata replicated to fill beat) << (8*off). Truncate to XLEN/8 and XLEN bits.
//  Load extract: raw=dresp_data>>(8*off); keep low 8<<size bits; sign-extend from MSB
//   unless in_unsigned or size=log2(XLEN/8). Store result: out_result=0.
//  Reset mid-transaction: return to IDLE next edge, drop dreq_valid, discard any later
//   data_ok. Bus is reset together with this stage.
//  Never more than one outstanding request; dreq_valid never asserted in IDLE/WAIT/OUT.
// STRUCTURE
//  Package mem_pkg: mem_op_e, msize_e, mas_state_e, function size_mask(size)->byte mask.
//  Sub-module mem_lane_align: combinational store shift/strobe gen + load extract/extend,
//   parametrised by XLEN; FSM, request reg and output reg live in mem_access_stage.
// TESTING (XLEN=64)
//  1 Non-mem op, in_result=0x1234, out_ready=1 -> out_valid next cycle, out_result=0x1234,
//    no dreq_valid.
//  2 LB addr=0x1003, dresp_data=0x00000000_80000000, addr_ok+data_ok same cycle ->
//    out_result=0xFFFF_FFFF_FFFF_FF80; LBU -> 0x80.
//  3 SH addr=0x2006, wdata=0xBEEF -> strobe=0xC0, dreq_data[63:48]=0xBEEF; addr_ok held
//    low 3 cycles: dreq_* stable throughout, in_ready=0.
//  4 LW addr=0x3002 -> out_misalign=1, out_result=0x3002, dreq_valid never asserted.
//  5 LD with data_ok 4 cycles after addr_ok and out_ready=0 for 2 cycles -> result held
//    stable; back-to-back second op accepted in the cycle out_ready rises.
//  6 reset asserted in WAIT, data_ok arrives after -> IDLE, no out_valid, response dropped.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types and helpers for the memory-access stage and its lane aligner.
package mem_pkg;

  // Memory operation requested by the execute stage
  typedef enum logic [1:0] {
    MOP_NONE  = 2'd0,
    MOP_LOAD  = 2'd1,
    MOP_STORE = 2'd2,
    MOP_RSVD  = 2'd3
  } mem_op_e;

  // Access size as log2 of the byte count
  typedef enum logic [1:0] {
    MSZ_B = 2'd0,
    MSZ_H = 2'd1,
    MSZ_W = 2'd2,
    MSZ_D = 2'd3
  } msize_e;

  // Stage FSM states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_OUT  = 2'd3
  } mas_state_e;

  // Byte-lane mask of an access of the given size, before shifting to its offset
  function automatic logic [7:0] size_mask(input logic [1:0] size);
    logic [7:0] m;
    case (size)
      2'd0:    m = 8'h01;
      2'd1:    m = 8'h03;
      2'd2:    m = 8'h0F;
      2'd3:    m = 8'hFF;
      default: m = 8'h00;
    endcase
    return m;
  endfunction

  // Address bits that must be zero for an access of the given size to be aligned
  function automatic logic [2:0] align_mask(input logic [1:0] size);
    logic [2:0] m;
    case (size)
      2'd0:    m = 3'd0;
      2'd1:    m = 3'd1;
      2'd2:    m = 3'd3;
      2'd3:    m = 3'd7;
      default: m = 3'd0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational lane steering: store data/strobe placement and misalign detection on the
// incoming op, and load extraction with sign/zero extension on the returned bus beat.
module mem_lane_align
  import mem_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [$clog2(XLEN/8)-1:0] i_st_off,
  input  logic [1:0]                i_st_size,
  input  logic [XLEN-1:0]           i_st_wdata,
  output logic [XLEN/8-1:0]         o_st_strobe,
  output logic [XLEN-1:0]           o_st_data,
  output logic                      o_st_misalign,
  input  logic [$clog2(XLEN/8)-1:0] i_ld_off,
  input  logic [1:0]                i_ld_size,
  input  logic                      i_ld_unsigned,
  input  logic [XLEN-1:0]           i_ld_rdata,
  output logic [XLEN-1:0]           o_ld_data
);

  localparam int LANES = XLEN / 8;
  localparam int OFF_W = $clog2(LANES);

  logic [XLEN-1:0] w_rep;
  logic [XLEN-1:0] w_raw;
  logic            w_msb;
  logic            w_sext;
  int              w_nbits;

  // Replicate the low element of the store data across every lane of the beat
  always_comb begin
    w_rep = '0;
    for (int b = 0; b < LANES; b++) begin
      w_rep[b*8 +: 8] = i_st_wdata[(b & int'(align_mask(i_st_size)))*8 +: 8];
    end
  end

  assign o_st_data     = w_rep << {i_st_off, 3'b000};
  assign o_st_strobe   = LANES'(size_mask(i_st_size)) << i_st_off;
  // Sizes wider than the bus are never legal; otherwise the low address bits must be clear
  assign o_st_misalign = (int'(i_st_size) > OFF_W) ||
                         ((i_st_off & OFF_W'(align_mask(i_st_size))) != '0);

  assign w_raw = i_ld_rdata >> {i_ld_off, 3'b000};

  // Width of the loaded element and its sign bit; a full-beat load is never extended
  always_comb begin
    w_nbits = XLEN;
    w_msb   = 1'b0;
    case (i_ld_size)
      2'd0: begin w_nbits = 8;  w_msb = w_raw[7];  end
      2'd1: begin w_nbits = 16; w_msb = w_raw[15]; end
      2'd2: begin w_nbits = 32; w_msb = w_raw[31]; end
      2'd3: begin w_nbits = 64; w_msb = w_raw[(XLEN >= 64) ? 63 : XLEN-1]; end
      default: begin w_nbits = XLEN; w_msb = 1'b0; end
    endcase
    if (w_nbits > XLEN) begin
      w_nbits = XLEN;
    end else begin
      w_nbits = w_nbits;
    end
    w_sext = !i_ld_unsigned && (int'(i_ld_size) < OFF_W);
  end

  // Keep the element bits and fill the rest with the sign bit or zero
  always_comb begin
    o_ld_data = '0;
    for (int i = 0; i < XLEN; i++) begin
      if (i < w_nbits) begin
        o_ld_data[i] = w_raw[i];
      end else begin
        o_ld_data[i] = w_sext & w_msb;
      end
    end
  end

endmodule

// File: rtl/mem_access_stage.sv
// Memory-access pipeline stage: accepts one op at a time from execute, issues at most one
// bus request with a valid/addr_ok/data_ok handshake, and presents a held result to writeback.
module mem_access_stage
  import mem_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [1:0]          in_mem_op,
  input  logic [1:0]          in_size,
  input  logic                in_unsigned,
  input  logic [XLEN-1:0]     in_addr,
  input  logic [XLEN-1:0]     in_wdata,
  input  logic [XLEN-1:0]     in_result,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [XLEN-1:0]     out_result,
  output logic                out_misalign,
  output logic                dreq_valid,
  output logic [XLEN-1:0]     dreq_addr,
  output logic [1:0]          dreq_size,
  output logic [XLEN/8-1:0]   dreq_strobe,
  output logic [XLEN-1:0]     dreq_data,
  input  logic                dresp_addr_ok,
  input  logic                dresp_data_ok,
  input  logic [XLEN-1:0]     dresp_data
);

  localparam int LANES = XLEN / 8;
  localparam int OFF_W = $clog2(LANES);

  mas_state_e        r_state;
  mem_op_e           r_op;
  logic [1:0]        r_size;
  logic              r_unsigned;
  logic [XLEN-1:0]   r_addr;
  logic [LANES-1:0]  r_strobe;
  logic [XLEN-1:0]   r_dreq_data;
  logic              r_dreq_valid;
  logic              r_out_valid;
  logic [XLEN-1:0]   r_out_result;
  logic              r_out_misalign;

  mem_op_e           w_in_op;
  logic              w_is_mem;
  logic              w_is_store;
  logic              w_accept;
  logic [LANES-1:0]  w_st_strobe;
  logic [XLEN-1:0]   w_st_data;
  logic              w_st_misalign;
  logic [XLEN-1:0]   w_ld_data;
  logic [XLEN-1:0]   w_done_result;

  assign w_in_op    = mem_op_e'(in_mem_op);
  assign w_is_mem   = (w_in_op == MOP_LOAD) || (w_in_op == MOP_STORE);
  assign w_is_store = (w_in_op == MOP_STORE);
  // Ready in IDLE, or in OUT when writeback takes the current result this cycle
  assign in_ready   = (r_state == ST_IDLE) || ((r_state == ST_OUT) && out_ready);
  assign w_accept   = in_valid && in_ready;
  // Stores write back zero; loads write back the extracted element
  assign w_done_result = (r_op == MOP_STORE) ? '0 : w_ld_data;

  mem_lane_align #(.XLEN(XLEN)) u_align (
    .i_st_off      (in_addr[OFF_W-1:0]),
    .i_st_size     (in_size),
    .i_st_wdata    (in_wdata),
    .o_st_strobe   (w_st_strobe),
    .o_st_data     (w_st_data),
    .o_st_misalign (w_st_misalign),
    .i_ld_off      (r_addr[OFF_W-1:0]),
    .i_ld_size     (r_size),
    .i_ld_unsigned (r_unsigned),
    .i_ld_rdata    (dresp_data),
    .o_ld_data     (w_ld_data)
  );

  // Stage FSM with request register and registered writeback/bus outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= ST_IDLE;
      r_op           <= MOP_NONE;
      r_size         <= 2'd0;
      r_unsigned     <= 1'b0;
      r_addr         <= '0;
      r_strobe       <= '0;
      r_dreq_data    <= '0;
      r_dreq_valid   <= 1'b0;
      r_out_valid    <= 1'b0;
      r_out_result   <= '0;
      r_out_misalign <= 1'b0;
    end else if (w_accept) begin
      r_op       <= w_in_op;
      r_size     <= in_size;
      r_unsigned <= in_unsigned;
      r_addr     <= in_addr;
      if (!w_is_mem) begin
        r_state        <= ST_OUT;
        r_out_valid    <= 1'b1;
        r_out_result   <= in_result;
        r_out_misalign <= 1'b0;
        r_dreq_valid   <= 1'b0;
        r_strobe       <= '0;
        r_dreq_data    <= '0;
      end else if (w_st_misalign) begin
        // Misaligned accesses never reach the bus; the faulting address goes to writeback
        r_state        <= ST_OUT;
        r_out_valid    <= 1'b1;
        r_out_result   <= in_addr;
        r_out_misalign <= 1'b1;
        r_dreq_valid   <= 1'b0;
        r_strobe       <= '0;
        r_dreq_data    <= '0;
      end else begin
        r_state        <= ST_REQ;
        r_out_valid    <= 1'b0;
        r_out_result   <= '0;
        r_out_misalign <= 1'b0;
        r_dreq_valid   <= 1'b1;
        r_strobe       <= w_is_store ? w_st_strobe : '0;
        r_dreq_data    <= w_is_store ? w_st_data : '0;
      end
    end else begin
      case (r_state)
        ST_REQ: begin
          if (dresp_addr_ok) begin
            r_dreq_valid <= 1'b0;
            if (dresp_data_ok) begin
              r_state        <= ST_OUT;
              r_out_valid    <= 1'b1;
              r_out_misalign <= 1'b0;
              r_out_result   <= w_done_result;
            end else begin
              r_state <= ST_WAIT;
            end
          end else begin
            r_state <= ST_REQ;
          end
        end
        ST_WAIT: begin
          if (dresp_data_ok) begin
            r_state        <= ST_OUT;
            r_out_valid    <= 1'b1;
            r_out_misalign <= 1'b0;
            r_out_result   <= w_done_result;
          end else begin
            r_state <= ST_WAIT;
          end
        end
        ST_OUT: begin
          if (out_ready) begin
            r_state     <= ST_IDLE;
            r_out_valid <= 1'b0;
          end else begin
            r_state <= ST_OUT;
          end
        end
        ST_IDLE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state      <= ST_IDLE;
          r_dreq_valid <= 1'b0;
          r_out_valid  <= 1'b0;
        end
      endcase
    end
  end

  assign out_valid    = r_out_valid;
  assign out_result   = r_out_result;
  assign out_misalign = r_out_misalign;
  assign dreq_valid   = r_dreq_valid;
  assign dreq_addr    = r_addr;
  assign dreq_size    = r_size;
  assign dreq_strobe  = r_strobe;
  assign dreq_data    = r_dreq_data;

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage (XLEN=64): vector table plus multi-cycle sequences.
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_mem_op;
  logic [1:0]  in_size;
  logic        in_unsigned;
  logic [63:0] in_addr;
  logic [63:0] in_wdata;
  logic [63:0] in_result;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_result;
  logic        out_misalign;
  logic        dreq_valid;
  logic [63:0] dreq_addr;
  logic [1:0]  dreq_size;
  logic [7:0]  dreq_strobe;
  logic [63:0] dreq_data;
  logic        dresp_addr_ok;
  logic        dresp_data_ok;
  logic [63:0] dresp_data;

  mem_access_stage #(.XLEN(64)) dut (
    .clk           (clk),
    .reset         (reset),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_mem_op     (in_mem_op),
    .in_size       (in_size),
    .in_unsigned   (in_unsigned),
    .in_addr       (in_addr),
    .in_wdata      (in_wdata),
    .in_result     (in_result),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_result    (out_result),
    .out_misalign  (out_misalign),
    .dreq_valid    (dreq_valid),
    .dreq_addr     (dreq_addr),
    .dreq_size     (dreq_size),
    .dreq_strobe   (dreq_strobe),
    .dreq_data     (dreq_data),
    .dresp_addr_ok (dresp_addr_ok),
    .dresp_data_ok (dresp_data_ok),
    .dresp_data    (dresp_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [1:0]  size;
    logic        uns;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [63:0] rdata;
    logic [63:0] exp_res;
    logic        exp_mis;
    int          exp_cyc;
    logic        exp_req;
    logic [7:0]  exp_strb;
    logic [63:0] exp_data;
  } vec_t;

  typedef struct {
    logic [63:0] res;
    logic        mis;
  } exp_t;

  localparam int NVEC = 17;
  vec_t vecs[NVEC];
  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic sb_pop_check(input string name);
    exp_t e;
    chk({name, "_sb_depth"}, 64'(sb.size()), 64'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk({name, "_result"}, out_result, e.res);
      chk({name, "_misalign"}, 64'(out_misalign), 64'(e.mis));
    end
  endtask

  task automatic drive_op(input logic [1:0] op, input logic [1:0] size, input logic uns,
                          input logic [63:0] addr, input logic [63:0] wdata,
                          input logic [63:0] result);
    in_valid    = 1'b1;
    in_mem_op   = op;
    in_size     = size;
    in_unsigned = uns;
    in_addr     = addr;
    in_wdata    = wdata;
    in_result   = result;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    string nm;
    bit    done;
    bit    req_seen;
    int    cyc;
    nm       = $sformatf("vec%0d", idx);
    done     = 1'b0;
    req_seen = 1'b0;
    cyc      = -1;
    @(negedge clk);
    chk({nm, "_in_ready"}, 64'(in_ready), 64'd1);
    drive_op(v.op, v.size, v.uns, v.addr, v.wdata,
             (v.op == 2'd1 || v.op == 2'd2) ? 64'hBAD0_BAD0_BAD0_BAD0 : v.exp_res);
    sb.push_back('{v.exp_res, v.exp_mis});
    @(posedge clk);
    #1 in_valid = 1'b0;
    for (int c = 0; c < 20 && !done; c++) begin
      @(negedge clk);
      dresp_addr_ok = 1'b0;
      dresp_data_ok = 1'b0;
      if (out_valid) begin
        sb_pop_check(nm);
        cyc  = c;
        done = 1'b1;
      end else if (dreq_valid) begin
        if (!req_seen) begin
          req_seen = 1'b1;
          chk({nm, "_dreq_addr"}, dreq_addr, v.addr);
          chk({nm, "_dreq_size"}, 64'(dreq_size), 64'(v.size));
          chk({nm, "_dreq_strobe"}, 64'(dreq_strobe), 64'(v.exp_strb));
          if (v.op == 2'd2) begin
            chk({nm, "_dreq_data"}, dreq_data, v.exp_data);
          end
        end
        dresp_addr_ok = 1'b1;
        dresp_data_ok = 1'b1;
        dresp_data    = v.rdata;
      end
    end
    chk({nm, "_latency"}, 64'(cyc), 64'(v.exp_cyc));
    chk({nm, "_req_seen"}, 64'(req_seen), 64'(v.exp_req));
    if (!done) begin
      sb.delete();
    end
  endtask

  // Bound the whole run in case the stage locks up
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //        op     size   uns   addr       wdata                   rdata                   exp_res                 mis  cyc req strb   exp_data
    vecs[0]  = '{2'd0, 2'd0, 1'b0, 64'h0,    64'h0,                  64'h0,                  64'h1234,               1'b0, 0, 1'b0, 8'h00, 64'h0};
    vecs[1]  = '{2'd1, 2'd0, 1'b0, 64'h1003, 64'h0,                  64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FF80, 1'b0, 1, 1'b1, 8'h00, 64'h0};
    vecs[2]  = '{2'd1, 2'd0, 1'b1, 64'h1003, 64'h0,                  64'h0000_0000_8000_0000, 64'h80,                 1'b0, 1, 1'b1, 8'h00, 64'h0};
    vecs[3]  = '{2'd2, 2'd1, 1'b0, 64'h2006, 64'hBEEF,               64'h0,                  64'h0,                  1'b0, 1, 1'b1, 8'hC0, 64'hBEEF_0000_0000_0000};
    vecs[4]  = '{2'd1, 2'd2, 1'b0, 64'h3002, 64'h0,                  64'h0,                  64'h3002,               1'b1, 0, 1'b0, 8'h00, 64'h0};
    vecs[5]  = '{2'd1, 2'd3, 1'b0, 64'h4000, 64'h0,                  64'h8123_4567_89AB_CDEF, 64'h8123_4567_89AB_CDEF, 1'b0, 1, 1'b1, 8'h00, 64'h0};
    vecs[6]  = '{2'd1, 2'd2, 1'b0, 64'h4004, 64'h0,                  64'h89AB_CDEF_0000_0000, 64'hFFFF_FFFF_89AB_CDEF, 1'b0, 1, 1'b1, 8'h00, 64'h0};
    vecs[7]  = '{2'd1, 2'd2, 1'b1, 64'h4004, 64'h0,                  64'h89AB_CDEF_0000_0000, 64'h0000_0000_89AB_CDEF, 1'b0, 1, 1'b1, 8'h00, 64'h0};
    vecs[8]  = '{2'd1, 2'd1, 1'b0, 64'h5002, 64'h0,                  64'h0000_0000_7FFF_0000, 64'h7FFF,               1'b0, 1, 1'b1, 8'h00, 64'h0};
    vecs[9]  = '{2'd1, 2'd1, 1'b1, 64'h5006, 64'h0,                  64'h8001_0000_0000_0000, 64'h8001,               1'b0, 1, 1'b1, 8'h00, 64'h0};
    vecs[10] = '{2'd1, 2'd1, 1'b0, 64'h5006, 64'h0,                  64'h8001_0000_0000_0000, 64'hFFFF_FFFF_FFFF_8001, 1'b0, 1, 1'b1, 8'h00, 64'h0};
    vecs[11] = '{2'd2, 2'd0, 1'b0, 64'h6005, 64'h1122_3344_5566_7788, 64'h0,                  64'h0,                  1'b0, 1, 1'b1, 8'h20, 64'h8888_8800_0000_0000};
    vecs[12] = '{2'd2, 2'd2, 1'b0, 64'h7004, 64'hDEAD_BEEF,          64'h0,                  64'h0,                  1'b0, 1, 1'b1, 8'hF0, 64'hDEAD_BEEF_0000_0000};
    vecs[13] = '{2'd2, 2'd3, 1'b0, 64'h8000, 64'h0102_0304_0506_0708, 64'h0,                  64'h0,                  1'b0, 1, 1'b1, 8'hFF, 64'h0102_0304_0506_0708};
    vecs[14] = '{2'd2, 2'd3, 1'b0, 64'h8004, 64'h0102_0304_0506_0708, 64'h0,                  64'h8004,               1'b1, 0, 1'b0, 8'h00, 64'h0};
    vecs[15] = '{2'd3, 2'd3, 1'b0, 64'h0003, 64'h0,                  64'h0,                  64'hCAFE,               1'b0, 0, 1'b0, 8'h00, 64'h0};
    vecs[16] = '{2'd2, 2'd1, 1'b0, 64'h2001, 64'hBEEF,               64'h0,                  64'h2001,               1'b1, 0, 1'b0, 8'h00, 64'h0};

    reset         = 1'b1;
    in_valid      = 1'b0;
    in_mem_op     = 2'd0;
    in_size       = 2'd0;
    in_unsigned   = 1'b0;
    in_addr       = 64'h0;
    in_wdata      = 64'h0;
    in_result     = 64'h0;
    out_ready     = 1'b1;
    dresp_addr_ok = 1'b0;
    dresp_data_ok = 1'b0;
    dresp_data    = 64'h0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_dreq_valid", 64'(dreq_valid), 64'd0);
    chk("rst_strobe", 64'(dreq_strobe), 64'd0);
    chk("rst_misalign", 64'(out_misalign), 64'd0);
    chk("rst_out_result", out_result, 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    reset = 1'b0;

    // Table of single transactions with an immediate bus response
    for (int i = 0; i < NVEC; i++) begin
      run_vec(vecs[i], i);
    end

    // Store stalled on addr_ok: request held, upstream stalled, early data_ok ignored
    @(negedge clk);
    drive_op(2'd2, 2'd1, 1'b0, 64'h2006, 64'hBEEF, 64'hBAD);
    sb.push_back('{64'd0, 1'b0});
    @(posedge clk);
    #1 in_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("seqA_dreq_valid_%0d", k), 64'(dreq_valid), 64'd1);
      chk($sformatf("seqA_addr_%0d", k), dreq_addr, 64'h2006);
      chk($sformatf("seqA_strobe_%0d", k), 64'(dreq_strobe), 64'hC0);
      chk($sformatf("seqA_data_%0d", k), dreq_data, 64'hBEEF_0000_0000_0000);
      chk($sformatf("seqA_in_ready_%0d", k), 64'(in_ready), 64'd0);
      chk($sformatf("seqA_out_valid_%0d", k), 64'(out_valid), 64'd0);
      dresp_addr_ok = 1'b0;
      dresp_data_ok = (k == 1);
    end
    @(negedge clk);
    dresp_data_ok = 1'b0;
    chk("seqA_still_req", 64'(dreq_valid), 64'd1);
    dresp_addr_ok = 1'b1;
    @(negedge clk);
    dresp_addr_ok = 1'b0;
    chk("seqA_wait_dreq", 64'(dreq_valid), 64'd0);
    chk("seqA_wait_out", 64'(out_valid), 64'd0);
    dresp_data_ok = 1'b1;
    @(negedge clk);
    dresp_data_ok = 1'b0;
    chk("seqA_out_valid", 64'(out_valid), 64'd1);
    sb_pop_check("seqA");

    // Load with delayed data, writeback stall, then back-to-back accept
    @(negedge clk);
    drive_op(2'd1, 2'd3, 1'b0, 64'h9000, 64'h0, 64'hBAD);
    sb.push_back('{64'h0123_4567_89AB_CDEF, 1'b0});
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    chk("seqB_req", 64'(dreq_valid), 64'd1);
    dresp_addr_ok = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      dresp_addr_ok = 1'b0;
      chk($sformatf("seqB_wait_dreq_%0d", k), 64'(dreq_valid), 64'd0);
      chk($sformatf("seqB_wait_out_%0d", k), 64'(out_valid), 64'd0);
    end
    @(negedge clk);
    dresp_data_ok = 1'b1;
    dresp_data    = 64'h0123_4567_89AB_CDEF;
    out_ready     = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      dresp_data_ok = 1'b0;
      dresp_data    = 64'hFFFF_FFFF_FFFF_FFFF;
      chk($sformatf("seqB_hold_valid_%0d", k), 64'(out_valid), 64'd1);
      chk($sformatf("seqB_hold_result_%0d", k), out_result, 64'h0123_4567_89AB_CDEF);
      chk($sformatf("seqB_hold_in_ready_%0d", k), 64'(in_ready), 64'd0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    drive_op(2'd0, 2'd0, 1'b0, 64'h0, 64'h0, 64'h5555);
    #1;
    chk("seqB_b2b_in_ready", 64'(in_ready), 64'd1);
    sb_pop_check("seqB_ld");
    sb.push_back('{64'h5555, 1'b0});
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    chk("seqB_b2b_valid", 64'(out_valid), 64'd1);
    sb_pop_check("seqB_b2b");

    // Reset while waiting for data: late data_ok must be dropped
    @(negedge clk);
    drive_op(2'd1, 2'd2, 1'b0, 64'hA000, 64'h0, 64'hBAD);
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    chk("seqC_req", 64'(dreq_valid), 64'd1);
    dresp_addr_ok = 1'b1;
    @(negedge clk);
    dresp_addr_ok = 1'b0;
    chk("seqC_wait", 64'(dreq_valid), 64'd0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("seqC_idle_ready", 64'(in_ready), 64'd1);
    chk("seqC_idle_out", 64'(out_valid), 64'd0);
    dresp_data_ok = 1'b1;
    dresp_data    = 64'h1111_2222_3333_4444;
    @(negedge clk);
    dresp_data_ok = 1'b0;
    chk("seqC_dropped_out", 64'(out_valid), 64'd0);
    chk("seqC_dropped_dreq", 64'(dreq_valid), 64'd0);
    @(negedge clk);
    chk("seqC_dropped_out2", 64'(out_valid), 64'd0);

    // Normal operation after the mid-transaction reset
    run_vec(vecs[1], 100);
    chk("sb_empty_at_end", 64'(sb.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
